// File: rtl/store_buffer.sv
// Store buffer: queues up to two stores per cycle in program order, drains them into
// the two data_memory write ports whenever loads leave them free, and forwards to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid1,
    input  logic        st_valid2,
    input  logic [31:0] st_addr1,
    input  logic [31:0] st_addr2,
    input  logic [31:0] st_data1,
    input  logic [31:0] st_data2,
    output logic        stall,
    input  logic        port_free1,
    input  logic        port_free2,
    output logic        mem_write1,
    output logic        mem_write2,
    output logic [31:0] mem_addr1,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_wdata1,
    output logic [31:0] mem_wdata2,
    input  logic [31:0] ld_addr1,
    input  logic [31:0] ld_addr2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];

    logic          acc1, acc2, wr1, wr2;
    logic [AW-1:0] slot2, head_p1, src2, fidx;
    logic [1:0]    n_enq, n_deq;
    logic          unused_bits;

    assign unused_bits = ^{st_addr1[1:0], st_addr2[1:0], ld_addr1[1:0], ld_addr2[1:0]};

    // Stall looks only at the registered count, so a same-cycle drain never releases it.
    assign stall   = (DEPTH_C - count_q) < (AW+1)'(2);
    assign head_p1 = head_q + AW'(1);

    always_comb begin
        wr1  = 1'b0;
        wr2  = 1'b0;
        src2 = head_q;
        if (port_free1 && port_free2) begin
            // Older entry on port 1 so memory's port-2 priority keeps the younger store.
            wr1  = (count_q != '0);
            wr2  = (count_q >= (AW+1)'(2));
            src2 = head_p1;
        end else if (port_free1) begin
            wr1 = (count_q != '0);
        end else if (port_free2) begin
            wr2 = (count_q != '0);
        end
        mem_write1 = wr1;
        mem_write2 = wr2;
        mem_addr1  = wr1 ? {addr_q[head_q], 2'b00} : 32'd0;
        mem_wdata1 = wr1 ? data_q[head_q] : 32'd0;
        mem_addr2  = wr2 ? {addr_q[src2], 2'b00} : 32'd0;
        mem_wdata2 = wr2 ? data_q[src2] : 32'd0;
        n_deq      = {1'b0, wr1} + {1'b0, wr2};
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        acc1   = !stall && st_valid1;
        acc2   = !stall && st_valid2;
        slot2  = tail_q + AW'(acc1);
        if (acc1) begin
            addr_d[tail_q] = st_addr1[31:2];
            data_d[tail_q] = st_data1;
        end
        if (acc2) begin
            addr_d[slot2] = st_addr2[31:2];
            data_d[slot2] = st_data2;
        end
        n_enq   = {1'b0, acc1} + {1'b0, acc2};
        tail_d  = tail_q + AW'(n_enq);
        head_d  = head_q + AW'(n_deq);
        count_d = count_q + (AW+1)'(n_enq) - (AW+1)'(n_deq);
    end

    // Scan oldest to youngest; later matches override, leaving the youngest.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = 32'd0;
        fwd_data2 = 32'd0;
        fidx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + AW'(i);
            if ((AW+1)'(i) < count_q) begin
                if (addr_q[fidx] == ld_addr1[31:2]) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[fidx];
                end
                if (addr_q[fidx] == ld_addr2[31:2]) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[fidx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents need no reset: nothing reads an unoccupied slot.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores are queued in program order and a
// negedge monitor checks every memory write against them.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid1, st_valid2;
    logic [31:0] st_addr1, st_addr2, st_data1, st_data2;
    logic        stall;
    logic        port_free1, port_free2;
    logic        mem_write1, mem_write2;
    logic [31:0] mem_addr1, mem_addr2, mem_wdata1, mem_wdata2;
    logic [31:0] ld_addr1, ld_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          exp_count = 0;
    int          acc_n = 0;

    store_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid1(st_valid1), .st_valid2(st_valid2),
        .st_addr1(st_addr1), .st_addr2(st_addr2),
        .st_data1(st_data1), .st_data2(st_data2),
        .stall(stall),
        .port_free1(port_free1), .port_free2(port_free2),
        .mem_write1(mem_write1), .mem_write2(mem_write2),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
        .ld_addr1(ld_addr1), .ld_addr2(ld_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected write: got addr %h data %h, expected no write", nm, a, d);
        end else begin
            e = exp_q.pop_front();
            if (a !== e.a || d !== e.d) begin
                errors++;
                $display("FAIL %s write: got %h/%h expected %h/%h", nm, a, d, e.a, e.d);
            end
        end
    endtask

    // Monitor: port 1 holds the older store when both ports write in one cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write1) begin
                pop_chk("port1", mem_addr1, mem_wdata1);
                mem_model[mem_addr1] = mem_wdata1;
            end
            if (mem_write2) begin
                pop_chk("port2", mem_addr2, mem_wdata2);
                mem_model[mem_addr2] = mem_wdata2;
            end
        end
    end

    task automatic cyc(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] a2, input logic [31:0] d2,
                       input logic p1, input logic p2);
        logic exp_stall;
        int   n, deq;
        @(posedge clk);
        #1;
        st_valid1 = v1; st_addr1 = a1; st_data1 = d1;
        st_valid2 = v2; st_addr2 = a2; st_data2 = d2;
        port_free1 = p1; port_free2 = p2;
        @(negedge clk);
        exp_stall = (4 - exp_count) < 2;
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        acc_n = 0;
        if (!exp_stall) begin
            if (v1) begin exp_q.push_back('{a1, d1}); acc_n++; end
            if (v2) begin exp_q.push_back('{a2, d2}); acc_n++; end
        end
        n   = (exp_count < 2) ? exp_count : 2;
        deq = (p1 && p2) ? n : ((p1 || p2) ? ((n >= 1) ? 1 : 0) : 0);
        exp_count = exp_count + acc_n - deq;
    endtask

    task automatic idle(input logic p1, input logic p2);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, p1, p2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, guard, v1i, v2i;
        logic [1:0] pat [6];
        pat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};

        reset = 1'b1;
        st_valid1 = 0; st_valid2 = 0; st_addr1 = 0; st_addr2 = 0; st_data1 = 0; st_data2 = 0;
        port_free1 = 1; port_free2 = 1; ld_addr1 = 32'h1000; ld_addr2 = 32'h1004;
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mw1", {31'd0, mem_write1}, 32'd0);
        chk("rst_mw2", {31'd0, mem_write2}, 32'd0);
        chk("rst_hit1", {31'd0, fwd_hit1}, 32'd0);
        chk("rst_hit2", {31'd0, fwd_hit2}, 32'd0);
        chk("rst_addr1", mem_addr1, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        idle(1, 1);
        chk("idle_mw1", {31'd0, mem_write1}, 32'd0);
        chk("idle_mw2", {31'd0, mem_write2}, 32'd0);

        // Pair enqueue then dual drain
        cyc(1, 32'h10, 32'hAAAA, 1, 32'h14, 32'hBBBB, 0, 0);
        idle(1, 1);
        chk("pair_mw1", {31'd0, mem_write1}, 32'd1);
        chk("pair_a1", mem_addr1, 32'h10);
        chk("pair_d1", mem_wdata1, 32'hAAAA);
        chk("pair_mw2", {31'd0, mem_write2}, 32'd1);
        chk("pair_a2", mem_addr2, 32'h14);
        chk("pair_d2", mem_wdata2, 32'hBBBB);
        idle(1, 1);
        chk("pair_empty_mw1", {31'd0, mem_write1}, 32'd0);
        chk("pair_empty_mw2", {31'd0, mem_write2}, 32'd0);

        // Same-address ordering, both ports then port 2 only
        cyc(1, 32'h20, 32'd1, 1, 32'h20, 32'd2, 0, 0);
        idle(1, 1);
        idle(1, 1);
        chk("same_both_mem", mem_model[32'h20], 32'd2);
        cyc(1, 32'h20, 32'd1, 1, 32'h20, 32'd2, 0, 0);
        idle(0, 1);
        chk("same_p2_first_mw1", {31'd0, mem_write1}, 32'd0);
        chk("same_p2_first", mem_wdata2, 32'd1);
        idle(0, 1);
        chk("same_p2_second", mem_wdata2, 32'd2);
        idle(1, 1);
        chk("same_p2_mem", mem_model[32'h20], 32'd2);

        // Fill and stall
        cyc(1, 32'h40, 32'h400, 1, 32'h44, 32'h440, 0, 0);
        cyc(1, 32'h48, 32'h480, 0, 32'd0, 32'd0, 0, 0);
        cyc(1, 32'h4C, 32'h4C0, 1, 32'h50, 32'h500, 0, 0);
        chk("fill_stall_at3", {31'd0, stall}, 32'd1);
        cyc(1, 32'h4C, 32'h4C0, 1, 32'h50, 32'h500, 1, 0);
        chk("fill_drain_a1", mem_addr1, 32'h40);
        chk("fill_still_stalled", {31'd0, stall}, 32'd1);
        idle(0, 0);
        chk("fill_stall_drop", {31'd0, stall}, 32'd0);
        idle(1, 1);
        idle(1, 1);

        // Forwarding
        ld_addr1 = 32'h30;
        cyc(1, 32'h30, 32'd5, 1, 32'h30, 32'd7, 0, 0);
        chk("fwd_same_cycle_hit1", {31'd0, fwd_hit1}, 32'd0);
        ld_addr1 = 32'h32; ld_addr2 = 32'h34;
        idle(0, 0);
        chk("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
        chk("fwd_data1", fwd_data1, 32'd7);
        chk("fwd_hit2", {31'd0, fwd_hit2}, 32'd0);
        idle(1, 0);
        chk("fwd_drain_hit1", {31'd0, fwd_hit1}, 32'd1);
        chk("fwd_drain_data1", fwd_data1, 32'd7);
        idle(1, 1);
        idle(0, 0);
        chk("fwd_gone_hit1", {31'd0, fwd_hit1}, 32'd0);

        // Reset with three entries queued
        cyc(1, 32'h60, 32'h600, 1, 32'h64, 32'h640, 0, 0);
        cyc(1, 32'h68, 32'h680, 0, 32'd0, 32'd0, 0, 0);
        @(posedge clk); #1;
        st_valid1 = 0; st_valid2 = 0; port_free1 = 1; port_free2 = 1;
        ld_addr1 = 32'h60;
        reset = 1'b1;
        exp_q.delete();
        exp_count = 0;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_mw1", {31'd0, mem_write1}, 32'd0);
        chk("midrst_hit1", {31'd0, fwd_hit1}, 32'd0);
        chk("midrst_fdata1", fwd_data1, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(1, 1);
            chk("postrst_mw1", {31'd0, mem_write1}, 32'd0);
            chk("postrst_mw2", {31'd0, mem_write2}, 32'd0);
        end

        // Pointer wrap: 12 stores with mixed drain patterns
        sent = 0;
        guard = 0;
        while (sent < 12 && guard < 200) begin
            v1i = (guard % 5 == 4) ? 0 : 1;
            v2i = ((sent + v1i) < 12 && (guard % 3 != 0)) ? 1 : 0;
            cyc(v1i[0], 32'h100 + 32'(4 * sent), 32'h5000 + 32'(sent),
                v2i[0], 32'h100 + 32'(4 * (sent + v1i)), 32'h5000 + 32'(sent + v1i),
                pat[guard % 6][0], pat[guard % 6][1]);
            sent += acc_n;
            guard++;
        end
        chk("wrap_all_sent", 32'(sent), 32'd12);
        guard = 0;
        while (exp_count != 0 && guard < 20) begin
            idle(1, 1);
            guard++;
        end
        idle(0, 0);
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer between the memory-stage issue slots and the dual-port `data_memory`. It accepts up to two stores per cycle from the two issue slots, queues them in program order, and drains them into the memory's two write ports when those ports are not claimed by loads. It also forwards buffered store data to same-word loads so that loads never read stale memory.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥2.
- `AW`, default 2: log2(DEPTH), the pointer width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `st_valid1`, `st_valid2`  in  1  store request from slot 1 / slot 2; slot 1 is older in program order.
- `st_addr1`, `st_addr2`  in  32  byte address of the store; only `[31:2]` is used.
- `st_data1`, `st_data2`  in  32  store word.
- `stall`  out  1  buffer cannot accept a store pair this cycle; upstream holds its stores.
- `port_free1`, `port_free2`  in  1  the memory port is not used by a load this cycle.
- `mem_write1`, `mem_write2`  out  1  drive `data_memory` `write1` / `write2`.
- `mem_addr1`, `mem_addr2`  out  32  write address for each port, valid when the matching `mem_write` is high.
- `mem_wdata1`, `mem_wdata2`  out  32  write data for each port.
- `ld_addr1`, `ld_addr2`  in  32  load lookup addresses.
- `fwd_hit1`, `fwd_hit2`  out  1  the load word matches a buffered entry.
- `fwd_data1`, `fwd_data2`  out  32  forwarded word, from the youngest matching entry.

## Operation
- Storage: circular array of `{word_addr[29:0], data[31:0]}`, plus `head` (oldest entry), `tail`, and `count` (0..DEPTH, width AW+1).
- Pointers are AW bits and wrap modulo DEPTH with no special case.
- Enqueue:
  - `stall = (DEPTH - count) < 2`, computed combinationally from registered `count` only. A drain in the same cycle does not lower stall.
  - When `stall` is 0, each valid store is written at the next tail slot. Slot 1 goes first.
  - If only `st_valid2` is high, it takes the first tail slot.
  - `tail` advances by the number of valid stores.
  - When `stall` is 1, all stores are ignored.
- Drain (combinational select, posedge pop):
  - n = number of entries available to drain = min(count, 2).
  - Both ports free and n ≥ 1: head goes on port 1. If n = 2, head+1 goes on port 2. This way the memory's port-2 priority on an equal-address double write keeps the younger store.
  - Exactly one port free and n ≥ 1: head goes on that port only.
  - No free port or count = 0: both `mem_write` outputs are 0.
  - `mem_addr` = `{word_addr, 2'b00}`. Memory writes at negedge. `head` advances by the number drained at the next posedge.
  - `count_next = count + enq - deq`; simultaneous enqueue and drain is legal.
- Forwarding (combinational):
  - For each load port, compare `ld_addr[31:2]` against every occupied entry.
  - Return the data of the youngest match, scanning from tail-1 back to head.
  - Stores enqueued in the current cycle are not visible until the next cycle. Same-bundle store-to-load ordering is the issue logic's job.
  - Entries draining this cycle still forward until popped.
- Non-power-of-two DEPTH is illegal and is not checked.

## Timing
- Reset (asynchronous): head = tail = count = 0.
  - While reset is high: `stall` = 0, `mem_write1/2` = 0, `fwd_hit1/2` = 0, `mem_addr`/`mem_wdata`/`fwd_data` = 0.
  - Entry contents are don't-care.
- Reset asserted mid-operation discards all buffered stores; none are written to memory after reset.
- Enqueue-to-drain latency: a store accepted at posedge N appears on `mem_write` in cycle N+1 at the earliest. It is written at the negedge of cycle N+1 and popped at posedge N+2.
- Enqueue-to-forward latency: one cycle, visible in cycle N+1.
- Throughput: two stores in and two drains per cycle when both ports are free.

## Test plan
- Reset then idle:
  - Required: `stall` = 0, `mem_write1/2` = 0, `fwd_hit1/2` = 0.
  - Assert reset with 3 entries queued; required: `count` = 0 and no memory writes after release.
- Pair enqueue and drain:
  - Stimulus: stores (0x10, 0xAAAA) in slot 1 and (0x14, 0xBBBB) in slot 2; next cycle both ports free.
  - Required: port 1 writes 0x10/0xAAAA and port 2 writes 0x14/0xBBBB in the same cycle; the buffer is empty after that cycle.
- Same-address ordering:
  - Stimulus: slot 1 (0x20, 1) and slot 2 (0x20, 2); both ports free.
  - Required: memory word 0x20 = 2.
  - With only port 2 free, drains run over two cycles (1 then 2), and the final value is 2.
- Fill and stall (DEPTH = 4):
  - Stimulus: enqueue 2+1 stores with ports busy.
  - Required: `stall` = 1 at count = 3; stores presented while stalled are not entered.
  - Free port 1 for one cycle: count 3→2, and `stall` drops in the following cycle.
- Forwarding:
  - Stimulus: queue (0x30, 5) then (0x30, 7) with ports busy; `ld_addr1` = 0x32.
  - Required: `fwd_hit1` = 1, `fwd_data1` = 7; `ld_addr2` = 0x34 gives `fwd_hit2` = 0.
- Pointer wrap: more than 2·DEPTH stores with partial drains; every store reaches memory exactly once, in order.
